wrapper_keys_tick: RTL and testbench
====================================

# wrapper_keys_tick

Parametrised input-conditioning and timing front end for the video test tops. It replaces the free-running divide-by-2 derived clock with a single-clock pixel clock-enable of programmable ratio. It also adds synchronised, debounced key inputs with press/release pulses and optional auto-repeat. Every game top then runs on `clk` and consumes `pix_ce` plus clean key events.

## Interface
- `NKEYS`, 4: number of key channels (1..16)
- `DIV`, 2: pixel-enable period in `clk` cycles (>=1)
- `DEB_CYCLES`, 4: consecutive stable cycles needed to accept a key change (>=1)
- `REPEAT`, 0: auto-repeat period in cycles while a key is held; 0 disables
- `KEYS_ACTIVE_LOW`, 0: 1 inverts raw `keys` before synchronisation

- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-low reset
- `keys` in NKEYS: raw asynchronous key inputs
- `pix_ce` out 1: one-cycle pixel clock-enable, period DIV
- `keys_db` out NKEYS: debounced key level, 1 = pressed
- `key_press` out NKEYS: one-cycle pulse on accepted press and on each auto-repeat
- `key_release` out NKEYS: one-cycle pulse on accepted release

## Operation
- Reset (`reset`=0, async): all flops clear; `pix_ce`, `keys_db`, `key_press`, `key_release` = 0; sync stages hold logical 0 (not pressed) regardless of `KEYS_ACTIVE_LOW`.
- Divider: `div_cnt` counts 0..DIV-1 and wraps. `pix_ce` is registered, high for exactly one cycle per wrap. DIV=1 gives `pix_ce` constantly 1 from the first edge after reset release.
- Per key: polarity fix (combinational), then 2-flop synchroniser giving `s2`, then a debounce counter `dcnt` of width $clog2(DEB_CYCLES+1).
  - `s2` != `keys_db` and `dcnt` == DEB_CYCLES-1: `keys_db` <= `s2`, `dcnt` <= 0, one-cycle `key_press` (0->1) or `key_release` (1->0).
  - `s2` != `keys_db` otherwise: `dcnt` increments.
  - `s2` == `keys_db`: `dcnt` <= 0. A glitch shorter than DEB_CYCLES is discarded entirely.
- Auto-repeat (REPEAT>0): `rcnt` clears on every accepted transition. While `keys_db`=1 with no transition, `rcnt` increments. At REPEAT-1 it pulses `key_press` and clears. `rcnt` is held at 0 while `keys_db`=0.
- Channels are fully independent. Simultaneous changes on several keys produce simultaneous pulses.

## Timing
- Divider: first `pix_ce` is high after rising edge DIV following reset release, then every DIV cycles.
- Debounce latency: the new level is first sampled at edge 1, reaches `s2` at edge 2, and `keys_db` plus the pulse update at edge 2+DEB_CYCLES.
- Repeat pulses follow at +REPEAT, +2·REPEAT, … cycles after the press pulse while held.
- A release accepted on the same edge a repeat would fire wins: `key_release`=1, `key_press`=0.
- Reset asserted mid-debounce or mid-repeat aborts immediately. No pulse is emitted on reset release even if keys are held; the press is then accepted via normal debounce.
- All outputs are registered. There is no combinational path from `keys` to any output.

## Structure
- Shared package/include `wrapper_pkg`: default values of DIV, DEB_CYCLES, REPEAT, NKEYS and the `$clog2` width helper.
- One sub-module, `key_debounce`, holding one channel (sync, debounce, repeat, pulses). It is instantiated NKEYS times by generate. The divider stays in the top.

## Test plan
- Reset then run, DIV=3: `pix_ce` high on edges 3, 6, 9…, each time for one cycle. With DIV=1, high continuously from edge 1.
- DEB_CYCLES=4, hold key0 high from edge 1: `keys_db[0]` and `key_press[0]` go 1 at edge 6. The pulse drops at edge 7. Release gives `key_release[0]` 6 edges later.
- Glitch: key1 high for 3 cycles with DEB_CYCLES=4 -> no change on `keys_db[1]`, no pulses.
- REPEAT=10, hold key2: press pulse at edge 6, then at 16, 26. Release timed to coincide with a repeat gives only `key_release`.
- KEYS_ACTIVE_LOW=1, all `keys`=4'b1111 -> `keys_db`=0. Drive `keys`=4'b1010 -> `keys_db`=4'b0101 with simultaneous press pulses on bits 0 and 2.
- Async reset asserted mid-debounce and mid-repeat -> outputs 0 immediately. A held key is re-accepted DEB_CYCLES+2 edges after release, with no spurious release pulse.

Source files
------------

// File: rtl/wrapper_pkg.sv
// Shared defaults, the per-channel event bundle and a width helper for the
// key/pixel-tick front end.
package wrapper_pkg;

   localparam int DEF_NKEYS      = 4;
   localparam int DEF_DIV        = 2;
   localparam int DEF_DEB_CYCLES = 4;
   localparam int DEF_REPEAT     = 0;

   typedef struct packed {
      logic level;
      logic press;
      logic rel;
   } key_evt_t;

   // Counter width for values 0..value-1, never narrower than one bit.
   function automatic int clog2w(input int value);
      return (value <= 1) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/key_debounce.sv
// One key channel: polarity fix, 2-flop synchroniser, debounce counter,
// optional auto-repeat and registered press/release pulses.
module key_debounce
   import wrapper_pkg::*;
#(
   parameter int DEB_CYCLES = DEF_DEB_CYCLES,
   parameter int REPEAT     = DEF_REPEAT,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic     i_clk,
   input  logic     i_rst_n,
   input  logic     i_key,
   output key_evt_t o_evt
);

   localparam int              DW       = clog2w(DEB_CYCLES + 1);
   localparam int              RW       = clog2w(REPEAT + 1);
   localparam logic [DW-1:0]   DEB_LAST = DW'(DEB_CYCLES - 1);
   localparam logic [RW-1:0]   RPT_LAST = RW'((REPEAT > 0) ? REPEAT - 1 : 0);

   logic          w_key;
   logic          w_accept;
   logic          r_s1;
   logic          r_s2;
   logic          r_db;
   logic          r_press;
   logic          r_rel;
   logic [DW-1:0] r_dcnt;
   logic [RW-1:0] r_rcnt;

   assign w_key    = i_key ^ ACTIVE_LOW;
   assign w_accept = (r_s2 != r_db) && (r_dcnt == DEB_LAST);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_db    <= 1'b0;
         r_press <= 1'b0;
         r_rel   <= 1'b0;
         r_dcnt  <= '0;
         r_rcnt  <= '0;
      end else begin
         r_s1    <= w_key;
         r_s2    <= r_s1;
         r_press <= 1'b0;
         r_rel   <= 1'b0;

         if (r_s2 == r_db) begin
            r_dcnt <= '0;
         end else if (w_accept) begin
            r_dcnt  <= '0;
            r_db    <= r_s2;
            r_press <= r_s2;
            r_rel   <= ~r_s2;
         end else begin
            r_dcnt <= r_dcnt + DW'(1);
         end

         // An accepted transition (notably a release) always overrides a repeat.
         if (w_accept || !r_db || (REPEAT == 0)) begin
            r_rcnt <= '0;
         end else if (r_rcnt == RPT_LAST) begin
            r_rcnt  <= '0;
            r_press <= 1'b1;
         end else begin
            r_rcnt <= r_rcnt + RW'(1);
         end
      end
   end

   assign o_evt.level = r_db;
   assign o_evt.press = r_press;
   assign o_evt.rel   = r_rel;

endmodule

// File: rtl/wrapper_keys_tick.sv
// Pixel clock-enable divider plus NKEYS independent debounced key channels,
// all running on the single system clock.
module wrapper_keys_tick
   import wrapper_pkg::*;
#(
   parameter int NKEYS           = DEF_NKEYS,
   parameter int DIV             = DEF_DIV,
   parameter int DEB_CYCLES      = DEF_DEB_CYCLES,
   parameter int REPEAT          = DEF_REPEAT,
   parameter int KEYS_ACTIVE_LOW = 0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [NKEYS-1:0] i_keys,
   output logic             o_pix_ce,
   output logic [NKEYS-1:0] o_keys_db,
   output logic [NKEYS-1:0] o_key_press,
   output logic [NKEYS-1:0] o_key_release
);

   localparam int            CW       = clog2w(DIV);
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

   logic [CW-1:0] r_div_cnt;
   logic          r_pix_ce;
   key_evt_t      w_evt [NKEYS];

   // With DIV=1 the wrap compare is always true, so pix_ce stays high.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_div_cnt <= '0;
         r_pix_ce  <= 1'b0;
      end else if (r_div_cnt == DIV_LAST) begin
         r_div_cnt <= '0;
         r_pix_ce  <= 1'b1;
      end else begin
         r_div_cnt <= r_div_cnt + CW'(1);
         r_pix_ce  <= 1'b0;
      end
   end

   assign o_pix_ce = r_pix_ce;

   generate
      for (genvar gi = 0; gi < NKEYS; gi++) begin : g_key
         key_debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .REPEAT     (REPEAT),
            .ACTIVE_LOW (KEYS_ACTIVE_LOW != 0)
         ) u_key (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_key   (i_keys[gi]),
            .o_evt   (w_evt[gi])
         );
         assign o_keys_db[gi]     = w_evt[gi].level;
         assign o_key_press[gi]   = w_evt[gi].press;
         assign o_key_release[gi] = w_evt[gi].rel;
      end
   endgenerate

endmodule

// File: tb/tb_wrapper_keys_tick.sv
// Scoreboard bench: two configurations of wrapper_keys_tick driven by the same
// logical key pattern, checked every cycle against a run-length reference model.
module tb_wrapper_keys_tick;

   localparam int NK = 4;

   // Instance 0: DIV=3, DEB=4, REPEAT=10, active-high keys.
   // Instance 1: DIV=1, DEB=1, REPEAT=0,  active-low keys (driven with ~logical).
   int cfg_div [2] = '{3, 1};
   int cfg_deb [2] = '{4, 1};
   int cfg_rep [2] = '{10, 0};

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic [NK-1:0] lk    = '0;
   logic [NK-1:0] raw_b;

   logic          a_pce, b_pce;
   logic [NK-1:0] a_db, a_pr, a_rl, b_db, b_pr, b_rl;

   assign raw_b = ~lk;

   wrapper_keys_tick #(.NKEYS(NK), .DIV(3), .DEB_CYCLES(4), .REPEAT(10), .KEYS_ACTIVE_LOW(0)) u_dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_keys(lk),
      .o_pix_ce(a_pce), .o_keys_db(a_db), .o_key_press(a_pr), .o_key_release(a_rl));

   wrapper_keys_tick #(.NKEYS(NK), .DIV(1), .DEB_CYCLES(1), .REPEAT(0), .KEYS_ACTIVE_LOW(1)) u_dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_keys(raw_b),
      .o_pix_ce(b_pce), .o_keys_db(b_db), .o_key_press(b_pr), .o_key_release(b_rl));

   always #5 clk = ~clk;

   typedef struct packed {
      logic          pce;
      logic [NK-1:0] db;
      logic [NK-1:0] pr;
      logic [NK-1:0] rl;
   } obs_t;

   typedef struct packed {
      obs_t a;
      obs_t b;
   } exp_t;

   exp_t sb[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // Reference model state: edge count since reset, debounced level, histories
   // of raw logical inputs and of the synchronised samples, last press edge.
   int          m_n      [2];
   logic        m_db     [2][NK];
   logic [31:0] m_xh     [2][NK];
   logic [31:0] m_sh     [2][NK];
   int          m_pressn [2][NK];

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_n[i] = 0;
         for (int k = 0; k < NK; k++) begin
            m_db[i][k]     = 1'b0;
            m_xh[i][k]     = '0;
            m_sh[i][k]     = '0;
            m_pressn[i][k] = 0;
         end
      end
   endfunction

   // Outputs after the next edge, given the logical keys held before it.
   // The synchroniser makes the debounce see the input from two edges back;
   // a change is accepted once the last DEB samples all differ from the level.
   function automatic obs_t model_edge(input int i, input logic [NK-1:0] x);
      obs_t o;
      logic s2;
      bit   run;
      o = '0;
      m_n[i]++;
      o.pce = ((m_n[i] % cfg_div[i]) == 0);
      for (int k = 0; k < NK; k++) begin
         s2 = m_xh[i][k][1];
         m_sh[i][k] = {m_sh[i][k][30:0], s2};
         m_xh[i][k] = {m_xh[i][k][30:0], x[k]};
         run = 1'b1;
         for (int j = 0; j < cfg_deb[i]; j++)
            if (m_sh[i][k][j] == m_db[i][k]) run = 1'b0;
         if (run) begin
            m_db[i][k] = ~m_db[i][k];
            if (m_db[i][k]) begin
               o.pr[k] = 1'b1;
               m_pressn[i][k] = m_n[i];
            end else begin
               o.rl[k] = 1'b1;
            end
         end else if (cfg_rep[i] > 0 && m_db[i][k]) begin
            if (((m_n[i] - m_pressn[i][k]) % cfg_rep[i]) == 0) o.pr[k] = 1'b1;
         end
         o.db[k] = m_db[i][k];
      end
      return o;
   endfunction

   task automatic check(input string name, input obs_t act, input obs_t exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s t=%0t actual pce=%b db=%b pr=%b rl=%b required pce=%b db=%b pr=%b rl=%b",
                  name, $time, act.pce, act.db, act.pr, act.rl, exp.pce, exp.db, exp.pr, exp.rl);
      end
   endtask

   // Called at a falling edge: drives keys for the coming rising edge and
   // records what both instances must show after it.
   task automatic step(input logic [NK-1:0] x);
      exp_t e;
      lk  = x;
      e.a = model_edge(0, x);
      e.b = model_edge(1, x);
      sb.push_back(e);
      @(negedge clk);
   endtask

   task automatic reset_mid();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("rst_async_a", {a_pce, a_db, a_pr, a_rl}, '0);
      check("rst_async_b", {b_pce, b_db, b_pr, b_rl}, '0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: every rising edge the DUTs present a new output word.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("dut_a", {a_pce, a_db, a_pr, a_rl}, e.a);
            check("dut_b", {b_pce, b_db, b_pr, b_rl}, e.b);
         end
      end
   end

   initial begin
      logic [NK-1:0] x;
      int            p;
      model_reset();
      #2 rst_n = 1'b0;
      #2;
      check("rst_init_a", {a_pce, a_db, a_pr, a_rl}, '0);
      check("rst_init_b", {b_pce, b_db, b_pr, b_rl}, '0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // key0 long hold, key1 3-cycle glitch, key2 released onto a repeat edge.
      for (int t = 1; t <= 40; t++) begin
         x    = '0;
         x[0] = (t <= 25);
         x[1] = (t >= 3 && t <= 5);
         x[2] = (t <= 20);
         step(x);
      end

      // Simultaneous press on bits 0 and 2, then all released.
      for (int t = 0; t < 10; t++) step(4'b0101);
      for (int t = 0; t < 10; t++) step(4'b0000);

      // Reset mid-debounce, re-accept while held, then reset mid-repeat.
      step(4'b1000);
      step(4'b1000);
      reset_mid();
      for (int t = 0; t < 23; t++) step(4'b1000);
      reset_mid();
      for (int t = 0; t < 10; t++) step(4'b1000);
      for (int t = 0; t < 10; t++) step(4'b0000);

      // Random phases alternating between chattery and long-hold behaviour.
      x = '0;
      for (int t = 0; t < 800; t++) begin
         p = (((t / 100) % 2) != 0) ? 3 : 25;
         for (int k = 0; k < NK; k++)
            if ($urandom_range(p - 1, 0) == 0) x[k] = ~x[k];
         step(x);
      end

      for (int t = 0; t < 12; t++) step(4'b0000);
      repeat (3) @(posedge clk);
      #2;
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain pending=%0d required=0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
